// File: rtl/reg_bank_pkg.sv
// Shared types for the two-host register bank: FSM states, host ids and address-decode classes.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    HOST_A,
    HOST_B
  } host_e;

  typedef enum logic [1:0] {
    CFG,
    STAT,
    ILLEGAL
  } dec_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-served pointer moves on every grant.
module rr_arbiter2
  import reg_bank_pkg::*;
(
  input  logic  clk,
  input  logic  rstb,
  input  logic  ena,
  input  logic  req_a,
  input  logic  req_b,
  output host_e grant_c,
  output logic  grant_valid_c
);

  host_e last_q;

  // On a tie the host that was not served last wins.
  always_comb begin
    grant_valid_c = ena && (req_a || req_b);
    grant_c       = HOST_A;
    if (req_a && req_b) begin
      grant_c = (last_q == HOST_A) ? HOST_B : HOST_A;
    end else if (req_b) begin
      grant_c = HOST_B;
    end
  end

  // Reset to "B served last" so host A wins the first tie.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= HOST_B;
    end else if (grant_valid_c) begin
      last_q <= grant_c;
    end
  end

endmodule

// File: rtl/reg_bank_arb.sv
// Config/status register bank shared by two serial hosts with round-robin req/ack arbitration.
module reg_bank_arb
  import reg_bank_pkg::*;
#(
  parameter int unsigned NUM_CFG    = 8,
  parameter int unsigned NUM_STATUS = 4,
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_W     = $clog2(NUM_CFG + NUM_STATUS),
  parameter logic [NUM_CFG*REG_WIDTH-1:0]    CFG_RESET   = '0,
  parameter logic [NUM_STATUS*REG_WIDTH-1:0] STICKY_MASK = '0
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic                            a_req,
  input  logic                            a_wr,
  input  logic [ADDR_W-1:0]               a_addr,
  input  logic [REG_WIDTH-1:0]            a_wdata,
  output logic                            a_ack,
  output logic [REG_WIDTH-1:0]            a_rdata,
  output logic                            a_err,
  input  logic                            b_req,
  input  logic                            b_wr,
  input  logic [ADDR_W-1:0]               b_addr,
  input  logic [REG_WIDTH-1:0]            b_wdata,
  output logic                            b_ack,
  output logic [REG_WIDTH-1:0]            b_rdata,
  output logic                            b_err,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_CFG-1:0]              cfg_upd,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

  localparam int unsigned STAT_BITS = NUM_STATUS * REG_WIDTH;

  state_e                 state_q, state_d;
  host_e                  host_q, grant;
  logic                   grant_valid;
  logic                   wr_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic [REG_WIDTH-1:0]   cfg_q [NUM_CFG];
  logic [REG_WIDTH-1:0]   stat_word [NUM_STATUS];
  logic [STAT_BITS-1:0]   sticky_q, clr;
  logic [NUM_CFG-1:0]     cfg_we;
  logic [REG_WIDTH-1:0]   acc_rdata;
  logic                   acc_err;
  logic                   do_acc;
  dec_e                   dec;
  int unsigned            addr_u;

  rr_arbiter2 u_arb (
    .clk           (clk),
    .rstb          (rstb),
    .ena           (ena && (state_q == IDLE)),
    .req_a         (a_req),
    .req_b         (b_req),
    .grant_c       (grant),
    .grant_valid_c (grant_valid)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    do_acc  = 1'b0;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = ACCESS;
      ACCESS: begin
        do_acc  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted host's command so it stays stable through ACCESS.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      host_q  <= HOST_A;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_valid) begin
      host_q <= grant;
      if (grant == HOST_B) begin
        wr_q    <= b_wr;
        addr_q  <= b_addr;
        wdata_q <= b_wdata;
      end else begin
        wr_q    <= a_wr;
        addr_q  <= a_addr;
        wdata_q <= a_wdata;
      end
    end
  end

  always_comb begin
    addr_u = 32'(addr_q);
    dec    = ILLEGAL;
    if (addr_u < NUM_CFG)                   dec = CFG;
    else if (addr_u < NUM_CFG + NUM_STATUS) dec = STAT;
  end

  // Readback view: live bits pass through, sticky bits come from the capture flops.
  always_comb begin
    for (int unsigned k = 0; k < NUM_STATUS; k++) begin
      stat_word[k] = (status_regs[k*REG_WIDTH +: REG_WIDTH] & ~STICKY_MASK[k*REG_WIDTH +: REG_WIDTH])
                   | (sticky_q[k*REG_WIDTH +: REG_WIDTH] & STICKY_MASK[k*REG_WIDTH +: REG_WIDTH]);
    end
  end

  always_comb begin
    acc_rdata = '0;
    acc_err   = 1'b0;
    cfg_we    = '0;
    clr       = '0;
    case (dec)
      CFG: begin
        for (int unsigned k = 0; k < NUM_CFG; k++) begin
          if (addr_u == k) begin
            if (wr_q) cfg_we[k] = do_acc;
            else      acc_rdata = cfg_q[k];
          end
        end
      end
      STAT: begin
        for (int unsigned k = 0; k < NUM_STATUS; k++) begin
          if (addr_u == NUM_CFG + k) begin
            if (wr_q) clr[k*REG_WIDTH +: REG_WIDTH] = do_acc ? wdata_q : '0;
            else      acc_rdata = stat_word[k];
          end
        end
      end
      default: acc_err = 1'b1;
    endcase
  end

  // Set wins over W1C in the same cycle so no status event is dropped.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        cfg_q[k] <= CFG_RESET[k*REG_WIDTH +: REG_WIDTH];
      end
      sticky_q <= '0;
      cfg_upd  <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CFG; k++) begin
        if (cfg_we[k]) cfg_q[k] <= wdata_q;
      end
      cfg_upd  <= cfg_we;
      sticky_q <= ((sticky_q & ~clr) | status_regs) & STICKY_MASK;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_ack   <= 1'b0;
      a_rdata <= '0;
      a_err   <= 1'b0;
      b_ack   <= 1'b0;
      b_rdata <= '0;
      b_err   <= 1'b0;
    end else begin
      a_ack <= do_acc && (host_q == HOST_A);
      b_ack <= do_acc && (host_q == HOST_B);
      if (do_acc && (host_q == HOST_A)) begin
        a_rdata <= acc_rdata;
        a_err   <= acc_err;
      end
      if (do_acc && (host_q == HOST_B)) begin
        b_rdata <= acc_rdata;
        b_err   <= acc_err;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_CFG; k++) begin
      config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_q[k];
    end
  end

endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed bench for reg_bank_arb with per-host scoreboards of expected read/err results.
module tb_reg_bank_arb;

  localparam int unsigned NC = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 4;
  localparam logic [NC*W-1:0] CR = 64'h0000_0000_0000_00A5;
  localparam logic [NS*W-1:0] SM = 32'h0000_0001;

  logic            clk, rstb, ena;
  logic            a_req, a_wr, a_ack, a_err;
  logic [AW-1:0]   a_addr;
  logic [W-1:0]    a_wdata, a_rdata;
  logic            b_req, b_wr, b_ack, b_err;
  logic [AW-1:0]   b_addr;
  logic [W-1:0]    b_wdata, b_rdata;
  logic [NC*W-1:0] config_regs;
  logic [NC-1:0]   cfg_upd;
  logic [NS*W-1:0] status_regs;

  typedef struct packed {
    logic [W-1:0] rd;
    logic         err;
    logic         chk;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  int            total = 0;
  int            bad   = 0;
  int            a_cyc, b_cyc;
  logic [NC-1:0] upd_at_ack;

  reg_bank_arb #(
    .NUM_CFG(NC), .NUM_STATUS(NS), .REG_WIDTH(W), .ADDR_W(AW),
    .CFG_RESET(CR), .STICKY_MASK(SM)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .config_regs(config_regs), .cfg_upd(cfg_upd), .status_regs(status_regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit hb, input bit wr, input logic [AW-1:0] ad, input logic [W-1:0] wd,
                       input logic [W-1:0] rd, input logic er, input logic chk);
    exp_t e;
    e = '{rd: rd, err: er, chk: chk};
    if (!hb) begin
      a_wr = wr; a_addr = ad; a_wdata = wd; a_req = 1'b1;
      qa.push_back(e);
    end else begin
      b_wr = wr; b_addr = ad; b_wdata = wd; b_req = 1'b1;
      qb.push_back(e);
    end
  endtask

  // Waits for outstanding requests to complete; pulse>0 raises status bit 0 over that cycle's closing edge.
  task automatic run(input int pulse);
    int   cyc;
    exp_t e;
    cyc   = 0;
    a_cyc = -1;
    b_cyc = -1;
    while ((a_req || b_req) && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (pulse != 0) status_regs[0] = (cyc == pulse);
      if (a_ack) begin
        a_cyc = cyc; a_req = 1'b0; upd_at_ack = cfg_upd;
        check("a_sb_has_entry", 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          if (e.chk) check("a_rdata", 64'(a_rdata), 64'(e.rd));
          check("a_err", 64'(a_err), 64'(e.err));
        end
      end
      if (b_ack) begin
        b_cyc = cyc; b_req = 1'b0; upd_at_ack = cfg_upd;
        check("b_sb_has_entry", 64'(qb.size() > 0), 64'd1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          if (e.chk) check("b_rdata", 64'(b_rdata), 64'(e.rd));
          check("b_err", 64'(b_err), 64'(e.err));
        end
      end
    end
    check("ack_timeout", 64'(a_req || b_req), 64'd0);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    int nack;
    rstb = 1'b0; ena = 1'b1; status_regs = '0;
    a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    upd_at_ack = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_config", config_regs, 64'h0000_0000_0000_00A5);
    check("rst_a_ack", 64'(a_ack), 64'd0);
    check("rst_b_ack", 64'(b_ack), 64'd0);
    check("rst_cfg_upd", 64'(cfg_upd), 64'd0);
    check("rst_a_rdata", 64'(a_rdata), 64'd0);
    check("rst_b_err", 64'(b_err), 64'd0);
    @(negedge clk) rstb = 1'b1;
    idle();

    // Solo read, write with update strobe, cross-host readback.
    issue(0, 0, 4'd0, 8'h00, 8'hA5, 1'b0, 1'b1); run(0);
    check("a_read_latency", 64'(a_cyc), 64'd2);
    idle();
    check("a_ack_one_cycle", 64'(a_ack), 64'd0);
    issue(0, 1, 4'd3, 8'h5C, 8'h00, 1'b0, 1'b0); run(0);
    check("upd_on_write", 64'(upd_at_ack), 64'h08);
    check("cfg3_value", 64'(config_regs[31:24]), 64'h5C);
    idle();
    check("upd_one_cycle", 64'(cfg_upd), 64'd0);
    issue(1, 0, 4'd3, 8'h00, 8'h5C, 1'b0, 1'b1); run(0);
    check("b_read_latency", 64'(b_cyc), 64'd2);
    idle();

    // Tie: last served was B, so A wins first.
    issue(0, 1, 4'd1, 8'h11, 8'h00, 1'b0, 1'b0);
    issue(1, 1, 4'd1, 8'h22, 8'h00, 1'b0, 1'b0);
    run(0);
    check("tie1_a_first", 64'(a_cyc), 64'd2);
    check("tie1_b_next", 64'(b_cyc), 64'd5);
    check("tie1_final", 64'(config_regs[15:8]), 64'h22);
    idle();
    issue(0, 0, 4'd1, 8'h00, 8'h22, 1'b0, 1'b1); run(0);
    idle();
    // Tie after A was served last: B wins first.
    issue(0, 1, 4'd1, 8'h11, 8'h00, 1'b0, 1'b0);
    issue(1, 1, 4'd1, 8'h22, 8'h00, 1'b0, 1'b0);
    run(0);
    check("tie2_b_first", 64'(b_cyc), 64'd2);
    check("tie2_a_next", 64'(a_cyc), 64'd5);
    check("tie2_final", 64'(config_regs[15:8]), 64'h11);
    idle();

    // Sticky capture, W1C, and set-over-clear collision.
    @(negedge clk) status_regs[0] = 1'b1;
    @(negedge clk) status_regs[0] = 1'b0;
    idle();
    issue(0, 0, 4'd8, 8'h00, 8'h01, 1'b0, 1'b1); run(0); idle();
    issue(0, 1, 4'd8, 8'h01, 8'h00, 1'b0, 1'b0); run(0); idle();
    issue(0, 0, 4'd8, 8'h00, 8'h00, 1'b0, 1'b1); run(0); idle();
    issue(0, 1, 4'd8, 8'h01, 8'h00, 1'b0, 1'b0); run(1); idle();
    issue(1, 0, 4'd8, 8'h00, 8'h01, 1'b0, 1'b1); run(0); idle();
    status_regs = 32'h0000_3C06;
    issue(0, 0, 4'd8, 8'h00, 8'h07, 1'b0, 1'b1); run(0); idle();
    issue(1, 0, 4'd9, 8'h00, 8'h3C, 1'b0, 1'b1); run(0); idle();

    // Out-of-range accesses: err, zero data, no side effects.
    issue(0, 0, 4'd12, 8'h00, 8'h00, 1'b1, 1'b1); run(0);
    check("illegal_no_upd", 64'(upd_at_ack), 64'd0);
    idle();
    issue(1, 1, 4'd15, 8'hFF, 8'h00, 1'b1, 1'b1); run(0);
    check("illegal_wr_no_upd", 64'(upd_at_ack), 64'd0);
    idle();
    check("cfg_image", config_regs, 64'h0000_0000_5C00_11A5);

    // Enable gating.
    ena = 1'b0;
    issue(0, 0, 4'd0, 8'h00, 8'hA5, 1'b0, 1'b1);
    nack = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_ack) nack++;
    end
    check("ena_low_no_ack", 64'(nack), 64'd0);
    ena = 1'b1;
    run(0);
    check("ena_resume_latency", 64'(a_cyc), 64'd2);
    idle();

    // Reset during ACCESS of a write aborts it.
    a_wr = 1'b1; a_addr = 4'd0; a_wdata = 8'h77; a_req = 1'b1;
    @(posedge clk); #1;
    rstb = 1'b0;
    #2;
    check("rst_mid_no_ack", 64'(a_ack), 64'd0);
    check("rst_mid_cfg0", 64'(config_regs[7:0]), 64'hA5);
    a_req = 1'b0;
    @(negedge clk) rstb = 1'b1;
    nack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (a_ack) nack++;
    end
    check("rst_mid_no_late_ack", 64'(nack), 64'd0);
    check("rst_mid_image", config_regs, 64'h0000_0000_0000_00A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_arb.md
Name: reg_bank_arb

Overview:
Parametrised register bank shared by two serial host peripherals: host A (SPI) and host B (I2C). It arbitrates their accesses round-robin over a req/ack handshake. Config and status register counts are independent. Status bits can be live or sticky with write-1-to-clear. It sits between the serial peripherals and the user design, and exports config registers plus per-register update strobes.

Parameters:
NUM_CFG, 8, number of read/write config registers; must be at least 1.
NUM_STATUS, 4, number of status registers; must be at least 1; need not equal NUM_CFG.
REG_WIDTH, 8, register width in bits.
ADDR_W, $clog2(NUM_CFG+NUM_STATUS), host address width; must be at least the default value.
CFG_RESET, '0, NUM_CFG*REG_WIDTH reset image of the config registers; register k occupies bits [k*REG_WIDTH +: REG_WIDTH].
STICKY_MASK, '0, NUM_STATUS*REG_WIDTH; a 1 makes that status bit sticky.

Ports:
clk  in  1  system clock
rstb  in  1  reset, asynchronous, active-low
ena  in  1  block enable; gates new grants only
a_req  in  1  host A request; held high until a_ack
a_wr  in  1  host A, 1=write, 0=read; stable while a_req
a_addr  in  ADDR_W  host A register address
a_wdata  in  REG_WIDTH  host A write data
a_ack  out  1  host A one-cycle completion pulse
a_rdata  out  REG_WIDTH  host A read data; valid with a_ack, held until the next A ack
a_err  out  1  host A address-out-of-range/illegal flag; valid with a_ack
b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata, b_err  same widths and roles as host A, for host B
config_regs  out  NUM_CFG*REG_WIDTH  flattened config registers
cfg_upd  out  NUM_CFG  one-cycle strobe per config register written
status_regs  in  NUM_STATUS*REG_WIDTH  live status inputs from the user design

Behaviour:
- Reset (asynchronous, rstb low):
  - FSM to IDLE.
  - config_regs = CFG_RESET.
  - sticky bits = 0.
  - all ack/err/cfg_upd = 0, all rdata = 0.
  - Round-robin pointer favours host A.
  - Reset mid-transaction aborts it: no write, no ack.
- FSM IDLE -> ACCESS -> DONE -> IDLE:
  - IDLE: if ena and any req, latch the granted host, its wr/addr/wdata; go to ACCESS. Otherwise stay.
  - ACCESS: perform the access at the closing edge. Register rdata/err and set the granted host's ack; go to DONE.
  - DONE: ack high for exactly this cycle; requests are ignored; go to IDLE.
  - Latency: req sampled high in cycle n -> ack high in cycle n+2. Maximum throughput is one access per 3 cycles.
- Arbitration:
  - Single requester: grant it.
  - Both requesting in IDLE: grant the host not served last; after reset this is host A.
  - The pointer updates on each grant.
  - The losing host keeps req high and is served next.
- ena low: no new grant. A transaction already in ACCESS/DONE completes normally.
- Address map:
  - 0..NUM_CFG-1 = config.
  - NUM_CFG..NUM_CFG+NUM_STATUS-1 = status, index addr-NUM_CFG.
  - Anything above is out of range: err=1, rdata=0, no side effects.
- Config write: the register takes wdata; its cfg_upd bit pulses in the cycle config_regs shows the new value (the DONE cycle).
- Config read: returns the current value.
- Status read: returns (live bits & ~STICKY_MASK) | (sticky bits & STICKY_MASK). Sampled at the ACCESS edge.
- Status write: for sticky bits, each 1 in wdata clears that bit (W1C). Non-sticky bits are ignored. err=0.
- Sticky update, every cycle: sticky <= (sticky & ~clr) | status_regs, masked by STICKY_MASK.
  - A simultaneous set and clear leaves the bit set; no event is lost.
- Widths: addr compared unsigned at ADDR_W bits; no wrap-around or aliasing of out-of-range addresses.

Decomposition:
- Package reg_bank_pkg:
  - FSM state enum (IDLE, ACCESS, DONE).
  - Host id enum (HOST_A, HOST_B).
  - Address-decode result enum (CFG, STAT, ILLEGAL).
- Sub-module rr_arbiter2:
  - Two requests plus enable in; grant and grant_valid out.
  - Owns the last-served pointer.
- The register storage and sticky logic stay in reg_bank_arb.

Test Plan:
- Reset with CFG_RESET=0x...A5 for register 0 -> config_regs[7:0]=0xA5, all other registers 0, no ack. Then A reads addr 0 -> a_ack exactly 2 cycles after a_req, a_rdata=0xA5, a_err=0.
- A writes addr 3 = 0x5C -> cfg_upd=0b00001000 for one cycle, config_regs[31:24]=0x5C. B reads addr 3 -> 0x5C.
- A and B request in the same cycle, A writes addr1=0x11, B writes addr1=0x22 -> A served first, B next; final value 0x22. Repeat simultaneously -> B served first.
- STICKY_MASK bit0 of status0 set; pulse status_regs[0] for 1 cycle -> read addr NUM_CFG bit0=1. Write 0x01 to addr NUM_CFG -> next read bit0=0. Clear coinciding with a new pulse -> bit stays 1.
- Read addr NUM_CFG+NUM_STATUS -> err=1, rdata=0, no cfg_upd. ena=0 with a_req high -> no ack until ena returns.
- Assert rstb low during ACCESS of a write -> no ack, register remains at CFG_RESET.
